// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite memory writer and line counter.
package sprite_pkg;

  localparam int SIZE_ADDRESS = 17;
  localparam int SIZE_LINE    = 20;
  localparam int SIZE_OFFSET  = 8;
  localparam int SIZE_DATA    = 9;
  localparam int NUM_SPRITES  = 32;

  // pixels per sprite slot
  localparam int SPRITE_AREA  = SIZE_LINE * SIZE_LINE;

  // RGB 3-3-3 pixel fields
  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } sprite_wr_state_t;

  // counter width able to hold 0..area-1
  function automatic int index_width(input int area);
    return (area <= 2) ? 1 : $clog2(area);
  endfunction

endpackage

// File: rtl/sprite_write_addr_gen.sv
// Slot base register, pixel index counter and last-pixel detect for sprite loads.
module sprite_write_addr_gen
  import sprite_pkg::*;
#(
  parameter int ADDR_W   = SIZE_ADDRESS,
  parameter int OFFSET_W = SIZE_OFFSET,
  parameter int AREA     = SPRITE_AREA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_is_last
);

  localparam int IDX_W = index_width(AREA);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AREA - 1);

  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_index;
  logic [ADDR_W-1:0] w_slot_base;

  // constant multiply: slot index to first address of the slot
  assign w_slot_base = ADDR_W'(i_offset) * ADDR_W'(AREA);

  // latch slot base on a new load, step index on each accepted pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_index <= '0;
    end else if (i_load) begin
      r_base  <= w_slot_base;
      r_index <= '0;
    end else if (i_advance) begin
      r_index <= o_is_last ? '0 : r_index + 1'b1;
    end
  end

  assign o_address = r_base + ADDR_W'(r_index);
  assign o_is_last = (r_index == LAST_IDX);

endmodule

// File: rtl/sprite_memory_writer.sv
// Streams one sprite (AREA pixels) into its memory slot during blanking.
module sprite_memory_writer
  import sprite_pkg::*;
#(
  parameter int size_address = SIZE_ADDRESS,
  parameter int size_line    = SIZE_LINE,
  parameter int size_offset  = SIZE_OFFSET,
  parameter int size_data    = SIZE_DATA,
  parameter int num_sprites  = NUM_SPRITES
) (
  input  logic                    clk_pixel,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [size_offset-1:0]  cmd_offset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [size_data-1:0]    pix_data,
  input  logic                    write_window,
  output logic [size_address-1:0] mem_address,
  output logic [size_data-1:0]    mem_data,
  output logic                    mem_wren,
  output logic                    busy,
  output logic                    write_finished,
  output logic                    cmd_error
);

  localparam int AREA = size_line * size_line;

  // every slot must be addressable by the memory port
  if (num_sprites * AREA > (1 << size_address)) begin : g_bound_check
    $error("sprite_memory_writer: num_sprites*area exceeds address space");
  end

  sprite_wr_state_t        r_state;
  logic                    r_cmd_ready;
  logic                    r_mem_wren;
  logic                    r_write_finished;
  logic                    r_cmd_error;
  logic [size_address-1:0] r_mem_address;
  logic [size_data-1:0]    r_mem_data;

  logic                    w_cmd_accept;
  logic                    w_offset_ok;
  logic                    w_load;
  logic                    w_pix_accept;
  logic                    w_is_last;
  logic [size_address-1:0] w_pix_address;

  assign w_cmd_accept = cmd_valid && r_cmd_ready;
  assign w_offset_ok  = (int'(cmd_offset) < num_sprites);
  assign w_load       = w_cmd_accept && w_offset_ok;
  // window gates the handshake so nothing is accepted while video reads
  assign pix_ready    = write_window && (r_state == WRITE);
  assign w_pix_accept = pix_valid && pix_ready;

  sprite_write_addr_gen #(
    .ADDR_W   (size_address),
    .OFFSET_W (size_offset),
    .AREA     (AREA)
  ) u_addr_gen (
    .clk       (clk_pixel),
    .reset     (reset),
    .i_load    (w_load),
    .i_offset  (cmd_offset),
    .i_advance (w_pix_accept),
    .o_address (w_pix_address),
    .o_is_last (w_is_last)
  );

  // load FSM with registered handshake, write port and status pulses
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cmd_ready      <= 1'b0;
      r_mem_wren       <= 1'b0;
      r_mem_address    <= '0;
      r_mem_data       <= '0;
      r_write_finished <= 1'b0;
      r_cmd_error      <= 1'b0;
    end else begin
      r_mem_wren       <= 1'b0;
      r_write_finished <= 1'b0;
      r_cmd_error      <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_accept) begin
            if (w_offset_ok) begin
              r_state     <= WRITE;
              r_cmd_ready <= 1'b0;
            end else begin
              r_cmd_error <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_pix_accept) begin
            r_mem_wren    <= 1'b1;
            r_mem_address <= w_pix_address;
            r_mem_data    <= pix_data;
            if (w_is_last) begin
              r_state          <= DONE;
              r_write_finished <= 1'b1;
            end
          end
        end
        DONE: begin
          // ready rises together with the return to IDLE
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign mem_wren       = r_mem_wren;
  assign mem_address    = r_mem_address;
  assign mem_data       = r_mem_data;
  assign write_finished = r_write_finished;
  assign cmd_error      = r_cmd_error;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_sprite_memory_writer.sv
// Directed self-checking bench for sprite_memory_writer.
module tb_sprite_memory_writer;

  localparam int AREA = 400;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_offset = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [8:0]  pix_data = '0;
  logic        write_window = 1'b0;
  logic [16:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        write_finished;
  logic        cmd_error;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_memory_writer dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_offset     (cmd_offset),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .write_window   (write_window),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_wren       (mem_wren),
    .busy           (busy),
    .write_finished (write_finished),
    .cmd_error      (cmd_error)
  );

  // 25 MHz pixel clock
  always #20 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"},      int'(cmd_ready), 0);
    check({tag, "_pix_ready"},      int'(pix_ready), 0);
    check({tag, "_mem_wren"},       int'(mem_wren), 0);
    check({tag, "_mem_address"},    int'(mem_address), 0);
    check({tag, "_mem_data"},       int'(mem_data), 0);
    check({tag, "_busy"},           int'(busy), 0);
    check({tag, "_write_finished"}, int'(write_finished), 0);
    check({tag, "_cmd_error"},      int'(cmd_error), 0);
  endtask

  // caller sits at a negedge; returns at the negedge where cmd_ready is seen high
  task automatic wait_cmd_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk_pixel);
      n++;
    end
    check({tag, "_cmd_ready_seen"}, int'(cmd_ready), 1);
  endtask

  // One sprite load. Pixel k carries value k, so every write must show
  // address base+k and data k. stall_at/rst_at < 0 disable those events.
  task automatic run_load(input string tag, input int off, input int stall_at,
                          input int stall_len, input int rst_at, input bit hold_cmd);
    int base, writes, bad, fin, fin_w, first, stall_left, stall_bad, rdy_bad;
    bit stall_done, stop;
    base = off * AREA;
    writes = 0; bad = 0; fin = 0; fin_w = -1; first = -1;
    stall_left = 0; stall_bad = 0; rdy_bad = 0;
    stall_done = 1'b0; stop = 1'b0;

    pix_valid    = 1'b1;
    pix_data     = '0;
    write_window = 1'b1;
    cmd_offset   = 8'(off);
    cmd_valid    = 1'b1;
    wait_cmd_ready(tag);
    @(negedge clk_pixel);
    check({tag, "_busy_after_accept"}, int'(busy), 1);
    check({tag, "_no_write_at_accept"}, int'(mem_wren), 0);
    if (hold_cmd) cmd_offset = 8'd5;
    else cmd_valid = 1'b0;

    for (int cyc = 1; cyc <= 1500 && !stop; cyc++) begin
      @(negedge clk_pixel);
      if (hold_cmd && cmd_ready) rdy_bad++;
      if (stall_left > 0 && (pix_ready || mem_wren)) stall_bad++;
      if (mem_wren) begin
        if (first < 0) first = cyc;
        if (int'(mem_address) != base + writes || int'(mem_data) != writes) bad++;
        if (write_finished) begin
          fin++;
          fin_w = writes;
        end
        writes++;
      end else if (write_finished) begin
        fin++;
      end
      pix_data = 9'(writes);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) write_window = 1'b1;
      end
      if (writes == stall_at && !stall_done) begin
        write_window = 1'b0;
        stall_left   = stall_len;
        stall_done   = 1'b1;
      end
      if (writes == rst_at) begin
        reset = 1'b1;
        stop  = 1'b1;
      end
      if (writes == AREA) begin
        check({tag, "_busy_in_done"}, int'(busy), 1);
        check({tag, "_cmd_ready_in_done"}, int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        stop = 1'b1;
      end
    end
    check({tag, "_finished_in_time"}, int'(stop), 1);

    check({tag, "_first_write_cycle"}, first, 1);
    check({tag, "_addr_data_errors"}, bad, 0);
    if (stall_at >= 0) check({tag, "_stall_errors"}, stall_bad, 0);
    if (hold_cmd) check({tag, "_cmd_ready_during_write"}, rdy_bad, 0);

    if (rst_at >= 0) begin
      check({tag, "_writes_before_reset"}, writes, rst_at);
      check({tag, "_no_finish_before_reset"}, fin, 0);
      @(negedge clk_pixel);
      check_all_zero({tag, "_after_reset"});
      reset = 1'b0;
    end else begin
      check({tag, "_write_count"}, writes, AREA);
      check({tag, "_finish_pulses"}, fin, 1);
      check({tag, "_finish_on_last"}, fin_w, AREA - 1);
      @(negedge clk_pixel);
      check({tag, "_busy_after_done"}, int'(busy), 0);
      check({tag, "_cmd_ready_after_done"}, int'(cmd_ready), 1);
      check({tag, "_wren_after_done"}, int'(mem_wren), 0);
      check({tag, "_finish_after_done"}, int'(write_finished), 0);
      check({tag, "_addr_held"}, int'(mem_address), base + AREA - 1);
    end
  endtask

  task automatic run_reject(input string tag, input int off);
    pix_valid    = 1'b1;
    write_window = 1'b1;
    cmd_offset   = 8'(off);
    cmd_valid    = 1'b1;
    wait_cmd_ready(tag);
    @(negedge clk_pixel);
    cmd_valid = 1'b0;
    check({tag, "_error_pulse"}, int'(cmd_error), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_pix_ready"}, int'(pix_ready), 0);
    check({tag, "_wren"}, int'(mem_wren), 0);
    @(negedge clk_pixel);
    check({tag, "_error_cleared"}, int'(cmd_error), 0);
    check({tag, "_wren_after"}, int'(mem_wren), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    check_all_zero("reset");
    reset = 1'b0;

    // pix_valid high in IDLE must not produce writes
    pix_valid = 1'b1;
    write_window = 1'b1;
    repeat (3) begin
      @(negedge clk_pixel);
      check("idle_pix_ignored", int'(mem_wren), 0);
    end

    run_load("normal_off8", 8, -1, 0, -1, 1'b0);
    run_load("data_off0", 0, -1, 0, -1, 1'b0);
    run_reject("reject_off40", 40);
    run_reject("reject_off32", 32);
    run_load("after_reject_off31", 31, -1, 0, -1, 1'b0);
    run_load("stall_off2", 2, 100, 50, -1, 1'b0);
    run_load("reset_off3", 3, -1, 0, 150, 1'b0);
    run_load("reload_off4", 4, -1, 0, -1, 1'b0);
    run_load("ignore_cmd_off6", 6, -1, 0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_memory_writer.md
Name: sprite_memory_writer

Overview:
Writer side of the sprite memory. The sprite_line_counter and draw path read this memory by address. This block accepts a command naming a sprite slot (offset), then streams size_line*size_line pixels into that slot through a valid/ready handshake. It only writes while write_window (vertical blank) is open, so it never collides with video reads.

Parameters:
size_address, 17, width of memory address (matches the reader side)
size_line, 20, sprite edge in pixels; sprite area = size_line*size_line = 400
size_offset, 8, width of sprite slot index
size_data, 9, pixel width (RGB 3-3-3)
num_sprites, 32, number of valid slots; offset >= num_sprites is rejected

Ports:
clk_pixel  in  1  pixel clock (25 MHz); only clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_offset  in  size_offset  target sprite slot
pix_valid  in  1  pixel stream valid
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_data  in  size_data  pixel value
write_window  in  1  1 = memory free for writing (blanking)
mem_address  out  size_address  write address
mem_data  out  size_data  write data
mem_wren  out  1  write strobe
busy  out  1  high while a sprite load is in progress (WRITE or DONE)
write_finished  out  1  one-cycle pulse with the last pixel write
cmd_error  out  1  one-cycle pulse on a rejected command

Behaviour:
- Clock and reset: one clock, clk_pixel. Reset is synchronous and active-high. Reset forces state=IDLE, index=0, base=0, and all outputs to 0.
- Reset mid-load abandons the load. The partially written sprite stays in memory. No write_finished pulse is issued.
- States: IDLE, WRITE, DONE.
- IDLE:
  - cmd_ready=1, pix_ready=0. pix_valid is ignored.
  - On accept with cmd_offset < num_sprites: base <= cmd_offset*AREA (constant multiply, zero-extended to size_address), index <= 0, next state WRITE.
  - On accept with cmd_offset >= num_sprites: cmd_error=1 on the next cycle, state stays IDLE, no writes.
- WRITE:
  - cmd_ready=0; cmd_valid is ignored (no queuing).
  - pix_ready = write_window (combinational; state==WRITE is implied).
  - Each accepted pixel increments index.
  - The accept at index==AREA-1 moves the state to DONE.
- Write timing:
  - Writes are registered, one cycle after acceptance: mem_wren=1, mem_address=base+index_at_accept, mem_data=pix_data_at_accept.
  - mem_wren is 0 in all other cycles, and mem_address/mem_data hold their last values.
- DONE:
  - Lasts exactly one cycle.
  - The last pixel's write (address base+AREA-1) occurs in this cycle, with write_finished=1.
  - Next state IDLE, so a new command can be accepted the cycle after DONE.
- Window rule: a write may land one cycle after write_window falls. The window owner must drop write_window at least one cycle before the reader uses the memory.
- Stalls: pix_valid=0 or write_window=0 pauses the stream with no write and no index change. Stalls of any length are allowed.
- Width and bound: max address = (num_sprites*AREA)-1 = 12799, which must be < 2^size_address. This is checked at elaboration (assertion).
- busy = (state != IDLE).

Decomposition:
- Shared package sprite_pkg: state encoding (IDLE/WRITE/DONE), SPRITE_AREA = size_line*size_line, RGB field widths. The same package serves sprite_line_counter.
- One sub-module, sprite_write_addr_gen: base register, constant multiply, index counter, and last-pixel detect. It outputs the address and an is_last flag.

Test Plan:
- Normal load: offset=8, pix_valid held 1, window=1 → first write at address 3200 two cycles after command accept; 400 consecutive writes, last at 3599; write_finished=1 only in that cycle; busy falls the cycle after.
- Data integrity: stream pixel values 0..399 into offset=0 → mem_address==mem_data for every write; exactly 400 mem_wren pulses.
- Rejected command: offset=40 with num_sprites=32 → cmd_error pulse one cycle after accept; no mem_wren; state stays IDLE; next valid command is accepted.
- Window stall: window=0 for 50 cycles after pixel 100 → pix_ready=0, no writes during the stall; resumes at base+100; total writes still 400.
- Reset mid-stream: reset at pixel 150 of offset=3 → next cycle all outputs 0, busy=0; a new command for offset=4 writes 1600..1999 and emits write_finished.
- Ignored inputs: cmd_valid during WRITE and pix_valid in IDLE → no effect, no writes, cmd_ready stays 0 until the cycle after DONE.
